// File: rtl/secded_pkg.sv
// -----------------------------------------------------------------------------
// secded_pkg
//   Shared types and constants for the SECDED decode engine.
//   - state_t : engine FSM states
//   - flag_t  : 2-bit per-message status written beside each recovered message
//   - default run geometry (message count, base addresses, address width)
//   - counter width and saturation value
// -----------------------------------------------------------------------------
package secded_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_LO,
        ST_RD_HI,
        ST_CAP_HI,
        ST_WR_LO,
        ST_WR_HI,
        ST_DONE
    } state_t;

    typedef logic [1:0] flag_t;

    localparam flag_t FLAG_OK  = 2'b00;  // clean codeword
    localparam flag_t FLAG_SEC = 2'b01;  // single error, corrected
    localparam flag_t FLAG_DED = 2'b10;  // double error, data left as read

    localparam int DEF_NUM_MSG  = 15;
    localparam int DEF_IN_BASE  = 30;
    localparam int DEF_OUT_BASE = 0;
    localparam int DEF_AW       = 8;

    localparam int             CNT_W   = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = 5'd31;

endpackage

// File: rtl/secded_decode.sv
// -----------------------------------------------------------------------------
// secded_decode
//   Purely combinational SECDED decoder for a 16-bit extended Hamming codeword.
//   Bit index equals Hamming position: data bits sit at the non-power-of-two
//   positions 3,5,6,7,9..15; p1,p2,p4,p8 at 1,2,4,8; overall parity p0 at 0.
//
// Ports
//   cw       in   16  codeword as read from memory
//   data     out  11  recovered message d11..d1 (corrected on a single error)
//   flag     out   2  FLAG_OK / FLAG_SEC / FLAG_DED
//   syndrome out   4  Hamming syndrome (position of a single flipped bit)
// -----------------------------------------------------------------------------
module secded_decode
    import secded_pkg::*;
(
    input  logic [15:0] cw,
    output logic [10:0] data,
    output flag_t       flag,
    output logic [3:0]  syndrome
);

    // Syndrome bit k covers every position whose index has bit k set
    // (position 0 is excluded from all four groups).
    localparam logic [15:0] MASK_S0 = 16'hAAAA;
    localparam logic [15:0] MASK_S1 = 16'hCCCC;
    localparam logic [15:0] MASK_S2 = 16'hF0F0;
    localparam logic [15:0] MASK_S3 = 16'hFF00;

    logic        parity;
    logic [10:0] data_flip;

    always_comb begin
        syndrome = {^(cw & MASK_S3), ^(cw & MASK_S2), ^(cw & MASK_S1), ^(cw & MASK_S0)};
        parity   = ^cw;

        // NOTE: data_flip gets a default before the case so syndromes that
        // point at a parity bit (or no bit) do not infer a latch.
        data_flip = '0;
        if (parity) begin
            // Map the erroneous Hamming position onto its message bit; a
            // syndrome of 0,1,2,4 or 8 means a parity bit took the hit.
            case (syndrome)
                4'd3:    data_flip = 11'h001;
                4'd5:    data_flip = 11'h002;
                4'd6:    data_flip = 11'h004;
                4'd7:    data_flip = 11'h008;
                4'd9:    data_flip = 11'h010;
                4'd10:   data_flip = 11'h020;
                4'd11:   data_flip = 11'h040;
                4'd12:   data_flip = 11'h080;
                4'd13:   data_flip = 11'h100;
                4'd14:   data_flip = 11'h200;
                4'd15:   data_flip = 11'h400;
                default: data_flip = '0;
            endcase
        end

        data = {cw[15:9], cw[7:5], cw[3]} ^ data_flip;

        // Odd overall parity means an odd number of flips: treat as single.
        // Even parity with a non-zero syndrome can only be a double error.
        if (parity) begin
            flag = FLAG_SEC;
        end else if (syndrome != 4'd0) begin
            flag = FLAG_DED;
        end else begin
            flag = FLAG_OK;
        end
    end

endmodule

// File: rtl/secded_dec_engine.sv
// -----------------------------------------------------------------------------
// secded_dec_engine
//   Walks NUM_MSG 16-bit codewords in byte-wide data memory, decodes each with
//   secded_decode and writes back the 11-bit message plus a 2-bit status.
//   Five cycles per message: RD_LO, RD_HI, CAP_HI, WR_LO, WR_HI.
//
// Ports
//   clk        in   1   system clock
//   rst_n      in   1   synchronous active-low reset
//   start      in   1   run request, honoured only in IDLE or DONE
//   done       out  1   high in DONE until the next accepted start
//   mem_addr   out  AW  byte address
//   mem_rd_en  out  1   read strobe; mem_rdata valid the following cycle
//   mem_rdata  in   8   read data
//   mem_wr_en  out  1   write strobe; memory writes at that rising edge
//   mem_wdata  out  8   write data
//   sec_cnt    out  5   corrected messages this run (saturating)
//   ded_cnt    out  5   double-error messages this run (saturating)
// -----------------------------------------------------------------------------
module secded_dec_engine
    import secded_pkg::*;
#(
    parameter int NUM_MSG  = DEF_NUM_MSG,
    parameter int IN_BASE  = DEF_IN_BASE,
    parameter int OUT_BASE = DEF_OUT_BASE,
    parameter int AW       = DEF_AW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             done,
    output logic [AW-1:0]    mem_addr,
    output logic             mem_rd_en,
    input  logic [7:0]       mem_rdata,
    output logic             mem_wr_en,
    output logic [7:0]       mem_wdata,
    output logic [CNT_W-1:0] sec_cnt,
    output logic [CNT_W-1:0] ded_cnt
);

    localparam int IDX_W = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [7:0]         cw_lo;
    logic [10:0]        res_data;
    flag_t              res_flag;

    logic [10:0]        dec_data;
    flag_t              dec_flag;
    logic [3:0]         unused_syndrome;  // visible for debug, not needed here

    // The high byte is decoded straight off mem_rdata in CAP_HI, so the
    // low-result write can be issued on the very next cycle.
    secded_decode u_decode (
        .cw       ({mem_rdata, cw_lo}),
        .data     (dec_data),
        .flag     (dec_flag),
        .syndrome (unused_syndrome)
    );

    function automatic logic [AW-1:0] byte_addr(input int base, input int msg, input int hi);
        return AW'(base + 2 * msg + hi);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    endfunction

    // Strobes and address are registered: each is set on the edge that
    // enters the state in which it must be visible.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            done      <= 1'b0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_wdata <= '0;
            sec_cnt   <= '0;
            ded_cnt   <= '0;
            cw_lo     <= '0;
            res_data  <= '0;
            res_flag  <= FLAG_OK;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every
            // register samples pre-edge values; later writes override the
            // strobe defaults below.
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (state == ST_DONE) begin
                        done <= 1'b1;
                    end
                    if (start) begin
                        state     <= ST_RD_LO;
                        idx       <= '0;
                        sec_cnt   <= '0;
                        ded_cnt   <= '0;
                        done      <= 1'b0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= byte_addr(IN_BASE, 0, 0);
                    end
                end

                ST_RD_LO: begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= byte_addr(IN_BASE, int'(idx), 1);
                    state     <= ST_RD_HI;
                end

                ST_RD_HI: begin
                    cw_lo <= mem_rdata;
                    state <= ST_CAP_HI;
                end

                ST_CAP_HI: begin
                    res_data  <= dec_data;
                    res_flag  <= dec_flag;
                    mem_wr_en <= 1'b1;
                    mem_addr  <= byte_addr(OUT_BASE, int'(idx), 0);
                    mem_wdata <= dec_data[7:0];
                    state     <= ST_WR_LO;
                end

                ST_WR_LO: begin
                    if (res_flag == FLAG_SEC) begin
                        sec_cnt <= sat_inc(sec_cnt);
                    end
                    if (res_flag == FLAG_DED) begin
                        ded_cnt <= sat_inc(ded_cnt);
                    end
                    mem_wr_en <= 1'b1;
                    mem_addr  <= byte_addr(OUT_BASE, int'(idx), 1);
                    mem_wdata <= {res_flag, 3'b000, res_data[10:8]};
                    state     <= ST_WR_HI;
                end

                ST_WR_HI: begin
                    if (int'(idx) == NUM_MSG - 1) begin
                        state <= ST_DONE;
                    end else begin
                        idx       <= idx + IDX_W'(1);
                        mem_rd_en <= 1'b1;
                        mem_addr  <= byte_addr(IN_BASE, int'(idx) + 1, 0);
                        state     <= ST_RD_LO;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secded_dec_engine.sv
// -----------------------------------------------------------------------------
// tb_secded_dec_engine
//   Self-checking bench for secded_dec_engine with a byte-wide memory model.
//   Expected results come from how each codeword was built (message value and
//   number of injected flips), not from decoding the codeword again.
// -----------------------------------------------------------------------------
module tb_secded_dec_engine;

    localparam int NUM_MSG  = 15;
    localparam int IN_BASE  = 30;
    localparam int OUT_BASE = 0;
    localparam int AW       = 8;
    localparam int RUN_LEN  = NUM_MSG * 5 + 1;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          done;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [7:0]    mem_rdata;
    logic          mem_wr_en;
    logic [7:0]    mem_wdata;
    logic [4:0]    sec_cnt;
    logic [4:0]    ded_cnt;

    secded_dec_engine #(
        .NUM_MSG  (NUM_MSG),
        .IN_BASE  (IN_BASE),
        .OUT_BASE (OUT_BASE),
        .AW       (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd_en (mem_rd_en),
        .mem_rdata (mem_rdata),
        .mem_wr_en (mem_wr_en),
        .mem_wdata (mem_wdata),
        .sec_cnt   (sec_cnt),
        .ded_cnt   (ded_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [7:0] in_mem  [0:255];
    logic [7:0] out_mem [0:255];
    logic       clr_out;
    int         wr_count = 0;
    int         overlap  = 0;

    always @(posedge clk) begin
        if (clr_out) begin
            for (int a = 0; a < 256; a++) out_mem[a] <= 8'hEE;
        end
        if (mem_wr_en) begin
            out_mem[mem_addr] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
        if (mem_rd_en) begin
            mem_rdata <= in_mem[mem_addr];
        end
        if (mem_rd_en && mem_wr_en) begin
            overlap <= overlap + 1;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] cw;
        int          n;
        logic        p;
        cw = '0;
        n  = 0;
        for (int j = 1; j < 16; j++) begin
            if ((j & (j - 1)) != 0) begin
                cw[j] = d[n];
                n++;
            end
        end
        for (int pb = 1; pb < 16; pb = pb * 2) begin
            p = 1'b0;
            for (int j = 1; j < 16; j++) begin
                if ((j & pb) != 0 && j != pb) p ^= cw[j];
            end
            cw[pb] = p;
        end
        cw[0] = ^cw[15:1];
        return cw;
    endfunction

    function automatic logic [10:0] extract(input logic [15:0] cw);
        logic [10:0] d;
        int          n;
        d = '0;
        n = 0;
        for (int j = 1; j < 16; j++) begin
            if ((j & (j - 1)) != 0) begin
                d[n] = cw[j];
                n++;
            end
        end
        return d;
    endfunction

    logic [7:0] exp_lo [NUM_MSG];
    logic [7:0] exp_hi [NUM_MSG];
    int         exp_sec;
    int         exp_ded;

    task automatic put_cw(input int i, input logic [15:0] cw);
        in_mem[IN_BASE + 2 * i]     = cw[7:0];
        in_mem[IN_BASE + 2 * i + 1] = cw[15:8];
    endtask

    task automatic load_random();
        logic [10:0] d;
        logic [15:0] cw;
        logic [10:0] ed;
        int          nf, p1, p2;
        exp_sec = 0;
        exp_ded = 0;
        for (int i = 0; i < NUM_MSG; i++) begin
            d  = 11'($urandom_range(0, 2047));
            cw = encode(d);
            nf = int'($urandom_range(0, 2));
            p1 = int'($urandom_range(0, 15));
            p2 = (p1 + int'($urandom_range(1, 15))) % 16;
            if (nf >= 1) cw[p1] = ~cw[p1];
            if (nf == 2) cw[p2] = ~cw[p2];
            // Up to one flip the original message comes back; with two the
            // raw (corrupted) data bits are passed through.
            ed = (nf == 2) ? extract(cw) : d;
            exp_lo[i] = ed[7:0];
            exp_hi[i] = {2'(nf), 3'b000, ed[10:8]};
            if (nf == 1) exp_sec++;
            if (nf == 2) exp_ded++;
            put_cw(i, cw);
        end
    endtask

    // Clears the result area, issues one start and counts edges to done.
    // rst_at > 0 asserts rst_n so that it is sampled at that edge, then returns.
    task automatic do_run(input bit pulses, input int rst_at, output int edges);
        @(negedge clk);
        clr_out = 1'b1;
        @(negedge clk);
        clr_out = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        check("done_low_after_start", 32'(done), 32'd0);
        edges = 0;
        while (edges < 200) begin
            @(posedge clk);
            edges++;
            #1;
            if (done) break;
            if (edges == rst_at) break;
            if (edges == rst_at - 1) rst_n = 1'b0;
            if (pulses && (edges == 7 || edges == 33 || edges == 61)) start = 1'b1;
            else start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic check_results(input string tag);
        for (int i = 0; i < NUM_MSG; i++) begin
            check($sformatf("%s_msg%0d_lo", tag, i), 32'(out_mem[OUT_BASE + 2 * i]), 32'(exp_lo[i]));
            check($sformatf("%s_msg%0d_hi", tag, i), 32'(out_mem[OUT_BASE + 2 * i + 1]), 32'(exp_hi[i]));
        end
        check({tag, "_sec_cnt"}, 32'(sec_cnt), 32'(exp_sec));
        check({tag, "_ded_cnt"}, 32'(ded_cnt), 32'(exp_ded));
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [15:0] cw;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [4:0]  sec;
        logic [4:0]  ded;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges;
        int wr_snap;

        rst_n   = 1'b0;
        start   = 1'b0;
        clr_out = 1'b0;
        for (int a = 0; a < 256; a++) in_mem[a] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_done",      32'(done),      32'd0);
        check("rst_rd_en",     32'(mem_rd_en), 32'd0);
        check("rst_wr_en",     32'(mem_wr_en), 32'd0);
        check("rst_addr",      32'(mem_addr),  32'd0);
        check("rst_wdata",     32'(mem_wdata), 32'd0);
        check("rst_sec_cnt",   32'(sec_cnt),   32'd0);
        check("rst_ded_cnt",   32'(ded_cnt),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs[0] = '{16'h000F, 8'h01, 8'h00, 5'd0, 5'd0};  // clean, d=1
        vecs[1] = '{16'h0007, 8'h01, 8'h40, 5'd1, 5'd0};  // d1 flipped
        vecs[2] = '{16'h000E, 8'h01, 8'h40, 5'd1, 5'd0};  // p0 flipped
        vecs[3] = '{16'h7FFF, 8'hFF, 8'h47, 5'd1, 5'd0};  // bit 15 flipped
        vecs[4] = '{16'h0009, 8'h01, 8'h80, 5'd0, 5'd1};  // bits 1,2 flipped
        vecs[5] = '{16'hFFFF, 8'hFF, 8'h07, 5'd0, 5'd0};  // clean, all ones

        // Each vector sits in message 0; the other slots hold clean zeros.
        for (int v = 0; v < 6; v++) begin
            for (int i = 1; i < NUM_MSG; i++) put_cw(i, 16'h0000);
            put_cw(0, vecs[v].cw);
            do_run(1'b0, -1, edges);
            check($sformatf("vec%0d_edges", v),  32'(edges),       32'(RUN_LEN));
            check($sformatf("vec%0d_lo", v),     32'(out_mem[0]),  32'(vecs[v].lo));
            check($sformatf("vec%0d_hi", v),     32'(out_mem[1]),  32'(vecs[v].hi));
            check($sformatf("vec%0d_sec", v),    32'(sec_cnt),     32'(vecs[v].sec));
            check($sformatf("vec%0d_ded", v),    32'(ded_cnt),     32'(vecs[v].ded));
            check($sformatf("vec%0d_last_lo", v), 32'(out_mem[2 * NUM_MSG - 2]), 32'd0);
        end

        // Random runs with start pulsed while busy.
        for (int r = 0; r < 3; r++) begin
            load_random();
            do_run(1'b1, -1, edges);
            check($sformatf("rand%0d_edges", r), 32'(edges), 32'(RUN_LEN));
            check_results($sformatf("rand%0d", r));
            check($sformatf("rand%0d_done_rd_en", r), 32'(mem_rd_en), 32'd0);
            check($sformatf("rand%0d_done_wr_en", r), 32'(mem_wr_en), 32'd0);
            repeat (2) @(posedge clk);
            #1;
            check($sformatf("rand%0d_done_held", r), 32'(done), 32'd1);
        end

        // Reset in the middle of a run.
        load_random();
        do_run(1'b0, 20, edges);
        wr_snap = wr_count;
        check("midrst_done",    32'(done),      32'd0);
        check("midrst_rd_en",   32'(mem_rd_en), 32'd0);
        check("midrst_wr_en",   32'(mem_wr_en), 32'd0);
        check("midrst_sec_cnt", 32'(sec_cnt),   32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_writes", 32'(wr_count), 32'(wr_snap));
        check("midrst_idle_done", 32'(done),     32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("midrst_kept%0d_lo", i), 32'(out_mem[OUT_BASE + 2 * i]),     32'(exp_lo[i]));
            check($sformatf("midrst_kept%0d_hi", i), 32'(out_mem[OUT_BASE + 2 * i + 1]), 32'(exp_hi[i]));
        end

        // Fresh run after the abort.
        load_random();
        do_run(1'b0, -1, edges);
        check("fresh_edges", 32'(edges), 32'(RUN_LEN));
        check_results("fresh");

        check("strobe_overlap", 32'(overlap), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
